// File: rtl/lr_sched_pkg.sv
// Shared definitions for the learning-rate scheduler: FSM state encoding
// and floating-point field helpers.
package lr_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default IEEE-754 single-precision field widths
   localparam int DEF_SIG_WIDTH = 23;
   localparam int DEF_EXP_WIDTH = 8;

   // The exponent field sits directly above the significand
   function automatic int exp_lsb(input int sig_width);
      return sig_width;
   endfunction

endpackage

// File: rtl/fp_exp_dec.sv
// Combinational exponent decrement: divides a float by 2^DECAY_SHIFT by
// lowering the exponent field, flushing to +0 when the result would be
// subnormal or zero.
module fp_exp_dec
   import lr_sched_pkg::*;
#(
   parameter int inst_sig_width = DEF_SIG_WIDTH,
   parameter int inst_exp_width = DEF_EXP_WIDTH,
   parameter int DECAY_SHIFT    = 1
) (
   input  logic [inst_sig_width+inst_exp_width:0] x,
   output logic [inst_sig_width+inst_exp_width:0] y
);

   localparam int W       = inst_sig_width + inst_exp_width + 1;
   localparam int EXP_LSB = exp_lsb(inst_sig_width);
   localparam logic [inst_exp_width-1:0] SHIFT_V = inst_exp_width'(DECAY_SHIFT);

   logic [inst_exp_width-1:0] exp_field;

   assign exp_field = x[EXP_LSB +: inst_exp_width];

   // Subtract the shift from the exponent; underflow (or zero input) gives +0
   always_comb begin
      y = '0;
      if (exp_field > SHIFT_V) begin
         y = {x[W-1], exp_field - SHIFT_V, x[inst_sig_width-1:0]};
      end
   end

endmodule

// File: rtl/lr_step_scheduler.sv
// Step-decay learning-rate scheduler: holds the current rate and divides it
// by 2^DECAY_SHIFT after every STEP_LEN accepted training steps, for
// LR_SIZE stages, then zeroes or holds the output.
module lr_step_scheduler
   import lr_sched_pkg::*;
#(
   parameter int inst_sig_width = 23,
   parameter int inst_exp_width = 8,
   parameter int LR_SIZE        = 7,
   parameter int STEP_LEN       = 4,
   parameter logic [inst_sig_width+inst_exp_width:0] INIT_LR = 32'h358637bd,
   parameter int DECAY_SHIFT    = 1,
   parameter int HOLD_LAST      = 0
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic                                    step,
   input  logic                                    decay_en,
   output logic [inst_sig_width+inst_exp_width:0]  lr,
   output logic [$clog2(LR_SIZE+1)-1:0]            stage,
   output logic                                    lr_update,
   output logic                                    done
);

   localparam int W  = inst_sig_width + inst_exp_width + 1;
   localparam int SW = $clog2(LR_SIZE + 1);
   localparam int CW = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_LEN - 1);
   localparam logic [SW-1:0] STAGE_END = SW'(LR_SIZE);

   state_t          state_reg, state_next;
   logic [W-1:0]    lr_reg, lr_next;
   logic [SW-1:0]   stage_reg, stage_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            lr_update_reg, lr_update_next;
   logic            done_reg, done_next;

   logic [W-1:0]    lr_dec;
   logic [SW-1:0]   stage_inc;

   fp_exp_dec #(
      .inst_sig_width (inst_sig_width),
      .inst_exp_width (inst_exp_width),
      .DECAY_SHIFT    (DECAY_SHIFT)
   ) u_exp_dec (
      .x (lr_reg),
      .y (lr_dec)
   );

   assign stage_inc = stage_reg + SW'(1);

   // State, counters and the lr register; reset aborts any schedule in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         lr_reg        <= '0;
         stage_reg     <= '0;
         cnt_reg       <= '0;
         lr_update_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         lr_reg        <= lr_next;
         stage_reg     <= stage_next;
         cnt_reg       <= cnt_next;
         lr_update_reg <= lr_update_next;
         done_reg      <= done_next;
      end
   end

   // Next-state logic: start always wins; steps only count in RUN with decay_en
   always_comb begin
      state_next     = state_reg;
      lr_next        = lr_reg;
      stage_next     = stage_reg;
      cnt_next       = cnt_reg;
      lr_update_next = 1'b0;

      if (start) begin
         state_next     = RUN;
         lr_next        = INIT_LR;
         stage_next     = '0;
         cnt_next       = '0;
         lr_update_next = 1'b1;
      end else begin
         case (state_reg)
            RUN: begin
               if (step && decay_en) begin
                  if (cnt_reg < CNT_LAST) begin
                     cnt_next = cnt_reg + CW'(1);
                  end else begin
                     cnt_next       = '0;
                     stage_next     = stage_inc;
                     lr_update_next = 1'b1;
                     if (stage_inc == STAGE_END) begin
                        state_next = DONE;
                        lr_next    = (HOLD_LAST != 0) ? lr_reg : '0;
                     end else begin
                        lr_next = lr_dec;
                     end
                  end
               end
            end
            DONE: begin
               stage_next = STAGE_END;
            end
            default: begin
               lr_next    = '0;
               stage_next = '0;
               cnt_next   = '0;
            end
         endcase
      end

      done_next = (state_next == DONE);
   end

   assign lr        = lr_reg;
   assign stage     = stage_reg;
   assign lr_update = lr_update_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_lr_step_scheduler.sv
// Directed bench for lr_step_scheduler: a default instance, a HOLD_LAST
// instance and an underflow instance share one stimulus stream.
module tb_lr_step_scheduler;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        step;
   logic        decay_en;

   logic [31:0] lr_a,  lr_h,  lr_u;
   logic [2:0]  stage_a, stage_h, stage_u;
   logic        upd_a, upd_h, upd_u;
   logic        done_a, done_h, done_u;

   int checks;
   int errors;

   lr_step_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .step      (step),
      .decay_en  (decay_en),
      .lr        (lr_a),
      .stage     (stage_a),
      .lr_update (upd_a),
      .done      (done_a)
   );

   lr_step_scheduler #(.HOLD_LAST(1)) dut_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .step      (step),
      .decay_en  (decay_en),
      .lr        (lr_h),
      .stage     (stage_h),
      .lr_update (upd_h),
      .done      (done_h)
   );

   lr_step_scheduler #(.INIT_LR(32'h00800000)) dut_uf (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .step      (step),
      .decay_en  (decay_en),
      .lr        (lr_u),
      .stage     (stage_u),
      .lr_update (upd_u),
      .done      (done_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, want);
      end else begin
         $display("ok   %s value=%h", tag, got);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Back-to-back step pulses, one per cycle
   task automatic do_steps(input int n);
      for (int i = 0; i < n; i++) begin
         step = 1'b1;
         tick();
      end
      step = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      step     = 1'b0;
      decay_en = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_lr",    lr_a, 32'h0);
      check("rst_stage", {29'b0, stage_a}, 32'd0);
      check("rst_upd",   {31'b0, upd_a}, 32'd0);
      check("rst_done",  {31'b0, done_a}, 32'd0);
      rst_n = 1'b1;
      tick();

      // step in IDLE is ignored
      do_steps(5);
      check("idle_lr",    lr_a, 32'h0);
      check("idle_stage", {29'b0, stage_a}, 32'd0);
      check("idle_upd",   {31'b0, upd_a}, 32'd0);

      // start -> INIT_LR with a one-cycle lr_update
      do_start();
      check("start_lr",    lr_a, 32'h358637bd);
      check("start_stage", {29'b0, stage_a}, 32'd0);
      check("start_upd",   {31'b0, upd_a}, 32'd1);
      check("start_done",  {31'b0, done_a}, 32'd0);
      tick();
      check("start_upd_drop", {31'b0, upd_a}, 32'd0);

      // Three steps: still stage 0, no update
      do_steps(3);
      check("cnt3_stage", {29'b0, stage_a}, 32'd0);
      check("cnt3_upd",   {31'b0, upd_a}, 32'd0);
      // Fourth step advances the stage
      do_steps(1);
      check("s1_lr",    lr_a, 32'h350637bd);
      check("s1_stage", {29'b0, stage_a}, 32'd1);
      check("s1_upd",   {31'b0, upd_a}, 32'd1);
      check("uf_lr",    lr_u, 32'h00000000);
      check("uf_stage", {29'b0, stage_u}, 32'd1);

      // Freeze: decay_en low, ten steps change nothing
      decay_en = 1'b0;
      do_steps(10);
      decay_en = 1'b1;
      check("frz_lr",    lr_a, 32'h350637bd);
      check("frz_stage", {29'b0, stage_a}, 32'd1);
      check("frz_upd",   {31'b0, upd_a}, 32'd0);

      // 24 accepted steps total -> stage 6
      do_steps(20);
      check("s6_lr",    lr_a, 32'h328637bd);
      check("s6_stage", {29'b0, stage_a}, 32'd6);
      check("s6_done",  {31'b0, done_a}, 32'd0);

      // 28 accepted steps -> schedule ends
      do_steps(4);
      check("end_stage",  {29'b0, stage_a}, 32'd7);
      check("end_done",   {31'b0, done_a}, 32'd1);
      check("end_upd",    {31'b0, upd_a}, 32'd1);
      check("end_lr",     lr_a, 32'h0);
      check("hold_lr",    lr_h, 32'h328637bd);
      check("hold_stage", {29'b0, stage_h}, 32'd7);
      check("hold_done",  {31'b0, done_h}, 32'd1);

      // Further steps in DONE: nothing moves
      do_steps(5);
      check("dn_stage",  {29'b0, stage_a}, 32'd7);
      check("dn_upd",    {31'b0, upd_a}, 32'd0);
      check("dn_lr",     lr_a, 32'h0);
      check("dn_hold_lr", lr_h, 32'h328637bd);
      check("dn_hold_upd", {31'b0, upd_h}, 32'd0);

      // Restart from DONE, run to stage 3 plus two counted steps
      do_start();
      check("rs_done",  {31'b0, done_a}, 32'd0);
      check("rs_lr",    lr_a, 32'h358637bd);
      do_steps(14);
      check("s3_stage", {29'b0, stage_a}, 32'd3);
      check("s3_lr",    lr_a, 32'h340637bd);

      // start + step collide: start wins, counter cleared
      start = 1'b1;
      step  = 1'b1;
      tick();
      start = 1'b0;
      step  = 1'b0;
      check("col_lr",    lr_a, 32'h358637bd);
      check("col_stage", {29'b0, stage_a}, 32'd0);
      check("col_upd",   {31'b0, upd_a}, 32'd1);
      do_steps(3);
      check("col_cnt3_stage", {29'b0, stage_a}, 32'd0);
      do_steps(1);
      check("col_cnt4_stage", {29'b0, stage_a}, 32'd1);

      // Reach stage 2, then assert reset asynchronously mid-cycle
      do_steps(4);
      check("pre_rst_stage", {29'b0, stage_a}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_lr",    lr_a, 32'h0);
      check("arst_stage", {29'b0, stage_a}, 32'd0);
      check("arst_done",  {31'b0, done_a}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      do_steps(6);
      check("post_rst_lr",    lr_a, 32'h0);
      check("post_rst_stage", {29'b0, stage_a}, 32'd0);
      do_start();
      check("post_rst_start", lr_a, 32'h358637bd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lr_step_scheduler.md
# lr_step_scheduler

Sequential learning-rate scheduler for the training datapath. Holds the current IEEE-754 learning rate in a register and applies step decay: after every `STEP_LEN` accepted training updates, the exponent field drops by `DECAY_SHIFT`, so the rate is divided by 2^`DECAY_SHIFT`. After `LR_SIZE` stages the schedule ends and the output is either zeroed or held. It sits between the training-control FSM, which issues `start` and `step`, and the weight-update multiplier, which consumes `lr`.

## Interface
- `inst_sig_width`, 23, significand width.
- `inst_exp_width`, 8, exponent width; W = `inst_sig_width`+`inst_exp_width`+1.
- `LR_SIZE`, 7, number of learning-rate stages (≥1).
- `STEP_LEN`, 4, accepted `step` pulses per stage (≥1).
- `INIT_LR`, 32'h358637bd (1e-6), stage-0 rate, W bits.
- `DECAY_SHIFT`, 1, exponent decrement per stage (≥0).
- `HOLD_LAST`, 0, behaviour after final stage: 0 → `lr`=0, 1 → hold stage `LR_SIZE`-1 value.

Ports:
- `clk` in 1, single clock, rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `start` in 1, single-cycle request: restart the schedule at stage 0.
- `step` in 1, single-cycle pulse: one training update completed.
- `decay_en` in 1, 0 freezes the stage and step counters (constant LR); sampled each cycle.
- `lr` out W, current learning rate (registered).
- `stage` out $clog2(`LR_SIZE`+1), current stage index, 0..`LR_SIZE`.
- `lr_update` out 1, one-cycle pulse in the first cycle a new `lr` value is visible.
- `done` out 1, high while the schedule is finished.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `lr`=0, `stage`=0, `step` ignored.
  - `start` in any state loads `lr`=`INIT_LR`, `stage`=0, cnt=0, and moves to RUN.
- RUN: on `step`&&`decay_en`:
  - If cnt < `STEP_LEN`-1, cnt++.
  - Else cnt=0 and `stage`++.
  - If the new stage < `LR_SIZE`: `lr` = dec(`lr`).
  - If the new stage == `LR_SIZE`: go to DONE, `lr` = 0 or hold, per `HOLD_LAST`.
- `step` with `decay_en`=0 is ignored; cnt is not advanced.
- DONE: `done`=1, `step` ignored, `stage`=`LR_SIZE`; only `start` leaves this state.
- dec(x):
  - Sign and significand are unchanged; the exponent field becomes exp−`DECAY_SHIFT`.
  - If exp ≤ `DECAY_SHIFT` (would become subnormal or zero), the result is +0 (all zeros). A zero `lr` stays zero.
- `start` and `step` in the same cycle: `start` wins and the `step` is dropped.
- `lr_update` pulses after every `start` and every stage advance, including the DONE entry, even if the value is unchanged.

## Timing
- Reset (async assert, sync release): `lr`=0, `stage`=0, cnt=0, `lr_update`=0, `done`=0, state IDLE.
- All outputs are registered; latency is 1 cycle:
  - `start` sampled at edge t → `lr`=`INIT_LR` and `lr_update`=1 during cycle t+1.
  - The `STEP_LEN`-th `step` sampled at edge t → new `lr`/`stage` plus `lr_update` during cycle t+1.
- No combinational path from inputs to outputs.
- Back-to-back `step` every cycle is legal; each pulse counts.
- Reset mid-RUN aborts immediately to IDLE values; no partial stage is retained.

## Structure
- Shared package `lr_sched_pkg`: state enum (IDLE/RUN/DONE) and the field-extract helper constants (exponent LSB position = `inst_sig_width`).
- Sub-module `fp_exp_dec`: combinational exponent decrement with underflow flush, parametrised by `inst_sig_width`, `inst_exp_width` and `DECAY_SHIFT`.
- Top module: FSM, step counter and `lr` register.

## Test plan
- Reset, then `start` → cycle+1: `lr`=32'h358637bd, `stage`=0, `lr_update`=1 for one cycle; `done`=0.
- 4 `step` pulses (defaults) → `lr`=32'h350637bd, `stage`=1. After 24 `step`s total → `lr`=32'h328637bd, `stage`=6.
- End of schedule: 28 `step`s → `stage`=7, `done`=1.
  - `HOLD_LAST`=0: `lr`=0.
  - `HOLD_LAST`=1: `lr`=32'h328637bd.
  - Further `step`s → no change, no `lr_update`.
- Freeze and collision:
  - `decay_en`=0 with 10 `step`s → `lr` and `stage` unchanged.
  - `start`+`step` in the same cycle during stage 3 → `lr`=`INIT_LR`, `stage`=0, cnt=0.
- Underflow: `INIT_LR`=32'h00800000, `DECAY_SHIFT`=1, 4 `step`s → `lr`=32'h00000000, `stage`=1.
- Async reset mid-RUN at stage 2 → `lr`=0, `stage`=0, `done`=0 immediately; `step` ignored until the next `start`.
